clk_divider_prog: RTL

- Multi-channel programmable clock-enable/clock divider for SoC peripheral timing (UART baud, timers, debug strobes).
- Each channel produces a divided square wave with runtime-programmable period and high time.
- Each channel also produces a single-cycle tick.
- Configuration updates apply glitch-free at period boundaries.
- Channels can be phase-aligned with a common restart.

---
 rtl/clk_divider_prog.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/clk_divider_prog.sv
// clk_divider_prog: multi-channel programmable clock divider.
// Each channel produces a divided square wave with a programmable period
// and high time. It also produces a one-cycle tick on the first high cycle
// of every period.
//
// Ports:
//   clk_in        source clock; all logic runs on its rising edge
//   rst_n         asynchronous active-low reset
//   cfg_valid     configuration write request
//   cfg_ready     write accepted when cfg_valid & cfg_ready
//                 (combinational on cfg_ch)
//   cfg_ch        target channel; out-of-range writes are accepted and dropped
//   cfg_div       requested period in clk_in cycles (clamped to >= 2)
//   cfg_high      requested high cycles per period (clamped to 1..div-1)
//   enable        per-channel run request
//   sync_restart  restarts the period of every running channel
//   clk_out       divided outputs, registered
//   tick          one-cycle pulse on the first high cycle of each period
//   running       channel is in RUN or STOPPING
module clk_divider_prog #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8,
    parameter int RST_DIV  = 2,
    parameter int RST_HIGH = 1,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic [CNT_W-1:0]    cfg_high,
    input  logic [CHANNELS-1:0] enable,
    input  logic                sync_restart,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] running
);

    // The reset configuration gets the same clamping as a written one.
    localparam int RST_DIV_C  = (RST_DIV < 2) ? 2 : RST_DIV;
    localparam int RST_HIGH_A = (RST_HIGH < 1) ? 1 : RST_HIGH;
    localparam int RST_HIGH_C = (RST_HIGH_A > RST_DIV_C - 1) ? RST_DIV_C - 1 : RST_HIGH_A;
    localparam logic [CNT_W-1:0] RST_DIV_V  = CNT_W'(RST_DIV_C);
    localparam logic [CNT_W-1:0] RST_HIGH_V = CNT_W'(RST_HIGH_C);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < CNT_W'(2)) ? CNT_W'(2) : d;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_high(input logic [CNT_W-1:0] d,
                                                    input logic [CNT_W-1:0] h);
        logic [CNT_W-1:0] de;
        logic [CNT_W-1:0] he;
        de = clamp_div(d);
        he = (h == '0) ? CNT_W'(1) : h;
        if (he > de - CNT_W'(1)) begin
            he = de - CNT_W'(1);
        end
        return he;
    endfunction

    logic [CHANNELS-1:0]  pending_vec;
    // Pad to a power of two so that out-of-range channel numbers read 0.
    // Writes to those channels are then always ready.
    logic [2**CH_W-1:0]   pending_pad;
    logic                 ch_in_range;

    assign pending_pad = (2**CH_W)'(pending_vec);
    assign cfg_ready   = ~pending_pad[cfg_ch];
    assign ch_in_range = ({1'b0, cfg_ch} < (CH_W+1)'(CHANNELS));

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] high_q, high_d;
        logic [CNT_W-1:0] sdiv_q, sdiv_d;
        logic [CNT_W-1:0] shigh_q, shigh_d;
        logic             pend_q, pend_d;
        logic             clk_out_q, clk_out_d;
        logic             tick_q, tick_d;
        logic             wrap;
        logic             apply;
        logic             accept;

        assign wrap   = (state_q != S_IDLE) && (cnt_q >= div_q - CNT_W'(1));
        assign accept = cfg_valid && cfg_ready && ch_in_range && (cfg_ch == CH_W'(gi));
        // The shadow is taken at a period boundary, on a restart, or at
        // any time while idle. Accept needs pend_q == 0, so the two never
        // collide. A simultaneous pair would still keep the new write
        // pending.
        assign apply  = pend_q && ((state_q == S_IDLE) || sync_restart || wrap);

        // State register
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                div_q     <= RST_DIV_V;
                high_q    <= RST_HIGH_V;
                sdiv_q    <= RST_DIV_V;
                shigh_q   <= RST_HIGH_V;
                pend_q    <= 1'b0;
                clk_out_q <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                div_q     <= div_d;
                high_q    <= high_d;
                sdiv_q    <= sdiv_d;
                shigh_q   <= shigh_d;
                pend_q    <= pend_d;
                clk_out_q <= clk_out_d;
                tick_q    <= tick_d;
            end
        end

        // Next-state logic. STOPPING only leaves for IDLE at a natural wrap.
        // This way the last period is never cut short.
        always_comb begin
            state_d = state_q;
            case (state_q)
                S_IDLE:  if (enable[gi]) state_d = S_RUN;
                S_RUN:   if (!enable[gi]) state_d = S_STOP;
                S_STOP: begin
                    if (enable[gi]) begin
                        state_d = S_RUN;
                    end else if (!sync_restart && wrap) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Counter and configuration datapath
        always_comb begin
            cnt_d   = cnt_q + CNT_W'(1);
            div_d   = div_q;
            high_d  = high_q;
            sdiv_d  = sdiv_q;
            shigh_d = shigh_q;
            pend_d  = pend_q;
            if ((state_q == S_IDLE) || sync_restart || wrap) begin
                cnt_d = '0;
            end
            if (apply) begin
                div_d  = sdiv_q;
                high_d = shigh_q;
                pend_d = 1'b0;
            end
            if (accept) begin
                sdiv_d  = clamp_div(cfg_div);
                shigh_d = clamp_high(cfg_div, cfg_high);
                pend_d  = 1'b1;
            end
        end

        // Outputs. Each output is registered from the count that held
        // before the edge. clk_out and tick therefore appear one edge
        // after the count reaches 0.
        always_comb begin
            clk_out_d = (state_q != S_IDLE) && (cnt_q < high_q);
            tick_d    = (state_q != S_IDLE) && (cnt_q == '0);
        end

        assign pending_vec[gi] = pend_q;
        assign clk_out[gi]     = clk_out_q;
        assign tick[gi]        = tick_q;
        assign running[gi]     = (state_q != S_IDLE);
    end

endmodule
